// File: rtl/wb_xbar_pipelined.sv
// wb_xbar_pipelined: 1-to-N Wishbone B4 pipelined interconnect with in-order routing, error slave and watchdog
module wb_xbar_pipelined #(
  parameter int          NUM_SLAVES      = 3,
  parameter logic [31:0] SLV_BASE [NUM_SLAVES] = '{32'h8000_0000, 32'h3000_0000, 32'h2000_0000},
  parameter logic [31:0] SLV_MASK [NUM_SLAVES] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wb_m_cyc_i,
  input  logic                       wb_m_stb_i,
  input  logic                       wb_m_we_i,
  input  logic [31:0]                wb_m_adr_i,
  input  logic [31:0]                wb_m_dat_i,
  input  logic [3:0]                 wb_m_sel_i,
  input  logic [2:0]                 wb_m_cti_i,
  input  logic [1:0]                 wb_m_bte_i,
  output logic                       wb_s_ack_o,
  output logic                       wb_s_err_o,
  output logic                       wb_s_rty_o,
  output logic                       wb_s_stall_o,
  output logic [31:0]                wb_s_dat_o,
  output logic [NUM_SLAVES-1:0]      wb_m_cyc_o,
  output logic [NUM_SLAVES-1:0]      wb_m_stb_o,
  output logic                       wb_m_we_o,
  output logic [31:0]                wb_m_adr_o,
  output logic [31:0]                wb_m_dat_o,
  output logic [3:0]                 wb_m_sel_o,
  output logic [2:0]                 wb_m_cti_o,
  output logic [1:0]                 wb_m_bte_o,
  input  logic [NUM_SLAVES-1:0]      wb_s_ack_i,
  input  logic [NUM_SLAVES-1:0]      wb_s_err_i,
  input  logic [NUM_SLAVES-1:0]      wb_s_rty_i,
  input  logic [NUM_SLAVES-1:0]      wb_s_stall_i,
  input  logic [NUM_SLAVES-1:0][31:0] wb_s_dat_i
);
  localparam int IDW = $clog2(NUM_SLAVES + 1);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW  = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDW-1:0] ERR_ID  = IDW'(NUM_SLAVES);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0]  cnt_q, cnt_d, err_pend_q, err_pend_d;
  logic [IDW-1:0] cur_q, cur_d, tgt;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic req, busy, live, tgt_real, cur_real, istall, stall, accept;
  logic s_ack, s_err, s_rty, es_fire, resp, tmo, done;

  // address decode; walking downwards lets the lowest matching index win
  always_comb begin
    tgt = ERR_ID;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((wb_m_adr_i & SLV_MASK[i]) == SLV_BASE[i]) tgt = IDW'(i);
  end

  assign req      = wb_m_cyc_i & wb_m_stb_i;
  assign busy     = cnt_q != '0;
  assign live     = wb_m_cyc_i & busy;
  assign tgt_real = tgt != ERR_ID;
  assign cur_real = cur_q != ERR_ID;
  assign istall   = req & ((cnt_q == MAX_CNT) | (busy & (tgt != cur_q)));
  assign stall    = istall | (req & tgt_real & wb_s_stall_i[tgt]);
  assign accept   = req & ~stall;
  assign s_ack    = live & cur_real & wb_s_ack_i[cur_q];
  assign s_err    = live & cur_real & wb_s_err_i[cur_q];
  assign s_rty    = live & cur_real & wb_s_rty_i[cur_q];
  assign es_fire  = live & ~cur_real & (err_pend_q != '0);
  assign resp     = s_ack | s_err | s_rty | es_fire;
  assign tmo      = (TIMEOUT_CYCLES != 0) & live & ~resp & (to_cnt_q == TO_LAST);
  assign done     = resp | tmo;

  assign wb_s_ack_o   = rst_ni & s_ack;
  assign wb_s_err_o   = rst_ni & (s_err | es_fire | tmo);
  assign wb_s_rty_o   = rst_ni & s_rty;
  assign wb_s_stall_o = rst_ni & stall;
  assign wb_s_dat_o   = (rst_ni & (s_ack | s_err | s_rty)) ? wb_s_dat_i[cur_q] : '0;

  assign wb_m_we_o  = wb_m_we_i;
  assign wb_m_adr_o = wb_m_adr_i;
  assign wb_m_dat_o = wb_m_dat_i;
  assign wb_m_sel_o = wb_m_sel_i;
  assign wb_m_cti_o = wb_m_cti_i;
  assign wb_m_bte_o = wb_m_bte_i;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_fwd
    assign wb_m_stb_o[g] = rst_ni & req & (tgt == IDW'(g)) & ~istall;
    assign wb_m_cyc_o[g] = rst_ni & wb_m_cyc_i & ((wb_m_stb_i & (tgt == IDW'(g))) | (busy & (cur_q == IDW'(g))));
  end

  // bookkeeping; a dropped master cyc abandons everything still in flight
  always_comb begin
    cnt_d      = wb_m_cyc_i ? cnt_q + CW'(accept) - CW'(done) : '0;
    err_pend_d = wb_m_cyc_i ? err_pend_q + CW'(accept & ~tgt_real) - CW'(es_fire) : '0;
    to_cnt_d   = (~wb_m_cyc_i | ~busy | accept | done | (TIMEOUT_CYCLES == 0)) ? '0 : to_cnt_q + 1'b1;
    cur_d      = accept ? tgt : cur_q;
  end

  // state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      err_pend_q <= '0;
      to_cnt_q   <= '0;
      cur_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      to_cnt_q   <= to_cnt_d;
      cur_q      <= cur_d;
    end
  end
endmodule
